// File: rtl/decode_stage_pipelined.sv
// Registered ARM-subset decode stage: classifies the incoming word, evaluates
// its condition against live flags, gathers operands (register file or bypass)
// and presents one decoded bundle per cycle to execute.
//
// Handshake: a transfer happens on a side in any cycle where its valid and
// ready are both high; valid never depends on ready, and a presented bundle
// stays unchanged until the consumer takes it.
module decode_stage_pipelined #(
    parameter int DATA_W  = 32,
    parameter int REG_AW  = 4,
    parameter int NUM_FWD = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [31:0]               instr_i,
    input  logic [3:0]                flags_i,
    output logic [REG_AW-1:0]         rr1_addr_o,
    output logic [REG_AW-1:0]         rr2_addr_o,
    output logic [REG_AW-1:0]         rr3_addr_o,
    output logic [REG_AW-1:0]         rr4_addr_o,
    input  logic [DATA_W-1:0]         rr1_data_i,
    input  logic [DATA_W-1:0]         rr2_data_i,
    input  logic [DATA_W-1:0]         rr3_data_i,
    input  logic [DATA_W-1:0]         rr4_data_i,
    input  logic [NUM_FWD-1:0]        fwd_valid_i,
    input  logic [NUM_FWD*REG_AW-1:0] fwd_dest_i,
    input  logic [NUM_FWD*DATA_W-1:0] fwd_data_i,
    input  logic                      pend_valid_i,
    input  logic [REG_AW-1:0]         pend_dest_i,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      out_exec,
    output logic [1:0]                out_class,
    output logic [3:0]                out_opcode,
    output logic [2:0]                out_type,
    output logic [REG_AW-1:0]         out_dest,
    output logic [DATA_W-1:0]         out_a,
    output logic [DATA_W-1:0]         out_b,
    output logic [DATA_W-1:0]         out_c,
    output logic [DATA_W-1:0]         out_d,
    output logic                      out_write_dest,
    output logic                      out_write_flags
);

    localparam logic [1:0] CLS_NOP   = 2'd0;
    localparam logic [1:0] CLS_DP    = 2'd1;
    localparam logic [1:0] CLS_MUL   = 2'd2;
    localparam logic [1:0] CLS_UNDEF = 2'd3;

    // Condition field against NZCV; 1111 never executes.
    function automatic logic cond_pass(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cf, v;
        {n, z, cf, v} = f;
        case (c)
            4'h0:    cond_pass = z;
            4'h1:    cond_pass = !z;
            4'h2:    cond_pass = cf;
            4'h3:    cond_pass = !cf;
            4'h4:    cond_pass = n;
            4'h5:    cond_pass = !n;
            4'h6:    cond_pass = v;
            4'h7:    cond_pass = !v;
            4'h8:    cond_pass = cf && !z;
            4'h9:    cond_pass = !cf || z;
            4'hA:    cond_pass = (n == v);
            4'hB:    cond_pass = (n != v);
            4'hC:    cond_pass = !z && (n == v);
            4'hD:    cond_pass = z || (n != v);
            4'hE:    cond_pass = 1'b1;
            default: cond_pass = 1'b0;
        endcase
    endfunction

    // Youngest matching bypass entry (lowest index) wins over the register file.
    function automatic logic [DATA_W-1:0] pick(
        input logic [REG_AW-1:0]         a,
        input logic [DATA_W-1:0]         rd,
        input logic [NUM_FWD-1:0]        v,
        input logic [NUM_FWD*REG_AW-1:0] d,
        input logic [NUM_FWD*DATA_W-1:0] x
    );
        pick = rd;
        for (int i = NUM_FWD - 1; i >= 0; i--) begin
            if (v[i] && (d[i*REG_AW +: REG_AW] == a)) pick = x[i*DATA_W +: DATA_W];
        end
    endfunction

    logic              is_nop, is_mul, is_dp;
    logic              use1, use2, use3, use4;
    logic              hazard, capture;
    logic [63:0]       imm_dbl;
    logic [31:0]       imm_rot;

    logic              valid_q;
    logic              exec_d, exec_q;
    logic [1:0]        class_d, class_q;
    logic [3:0]        opcode_d, opcode_q;
    logic [2:0]        type_d, type_q;
    logic [REG_AW-1:0] dest_d, dest_q;
    logic [DATA_W-1:0] a_d, a_q, b_d, b_q, c_d, c_q, d_d, d_q;
    logic              wdest_d, wdest_q, wflags_d, wflags_q;

    // Instruction class; NOP is carved out of the data-processing space first.
    always_comb begin
        is_nop = (instr_i[27:0] == 28'h320F000);
        is_mul = !is_nop && (instr_i[27:25] == 3'b000) && instr_i[7] && instr_i[4];
        is_dp  = !is_nop && !is_mul && (instr_i[27:26] == 2'b00);
    end

    // Register-file read addresses and which of them the class really consumes.
    always_comb begin
        rr1_addr_o = '0;
        rr2_addr_o = '0;
        rr3_addr_o = '0;
        rr4_addr_o = '0;
        use1 = 1'b0;
        use2 = 1'b0;
        use3 = 1'b0;
        use4 = 1'b0;
        if (is_dp) begin
            rr1_addr_o = REG_AW'(instr_i[19:16]);
            rr2_addr_o = REG_AW'(instr_i[3:0]);
            use1 = 1'b1;
            use2 = !instr_i[25];
        end else if (is_mul) begin
            rr1_addr_o = REG_AW'(instr_i[3:0]);
            rr2_addr_o = REG_AW'(instr_i[11:8]);
            rr3_addr_o = REG_AW'(instr_i[19:16]);
            rr4_addr_o = REG_AW'(instr_i[15:12]);
            use1 = 1'b1;
            use2 = 1'b1;
            use3 = 1'b1;
            use4 = 1'b1;
        end
    end

    // Stall while a consumed source still waits on an in-flight result.
    always_comb begin
        hazard = in_valid && pend_valid_i &&
                 ((use1 && (rr1_addr_o == pend_dest_i)) ||
                  (use2 && (rr2_addr_o == pend_dest_i)) ||
                  (use3 && (rr3_addr_o == pend_dest_i)) ||
                  (use4 && (rr4_addr_o == pend_dest_i)));
        in_ready = (!valid_q || out_ready) && !hazard;
        capture  = in_valid && in_ready;
    end

    // Next bundle: rotated immediate, operands, destination and gated write enables.
    always_comb begin
        imm_dbl  = {24'b0, instr_i[7:0], 24'b0, instr_i[7:0]} >> {instr_i[11:8], 1'b0};
        imm_rot  = imm_dbl[31:0];
        exec_d   = cond_pass(instr_i[31:28], flags_i);
        class_d  = is_nop ? CLS_NOP : is_mul ? CLS_MUL : is_dp ? CLS_DP : CLS_UNDEF;
        opcode_d = 4'd0;
        type_d   = 3'd0;
        dest_d   = '0;
        a_d      = '0;
        b_d      = '0;
        c_d      = '0;
        d_d      = '0;
        wdest_d  = 1'b0;
        wflags_d = 1'b0;
        if (is_dp) begin
            opcode_d = instr_i[24:21];
            dest_d   = REG_AW'(instr_i[15:12]);
            a_d      = pick(rr1_addr_o, rr1_data_i, fwd_valid_i, fwd_dest_i, fwd_data_i);
            b_d      = instr_i[25] ? DATA_W'(imm_rot)
                                   : pick(rr2_addr_o, rr2_data_i, fwd_valid_i, fwd_dest_i, fwd_data_i);
            // Compare/test opcodes only ever touch the flags.
            if (instr_i[24:23] == 2'b10) begin
                wdest_d  = 1'b0;
                wflags_d = 1'b1;
            end else begin
                wdest_d  = 1'b1;
                wflags_d = instr_i[20];
            end
        end else if (is_mul) begin
            type_d   = instr_i[23:21];
            dest_d   = REG_AW'(instr_i[19:16]);
            a_d      = pick(rr1_addr_o, rr1_data_i, fwd_valid_i, fwd_dest_i, fwd_data_i);
            b_d      = pick(rr2_addr_o, rr2_data_i, fwd_valid_i, fwd_dest_i, fwd_data_i);
            c_d      = pick(rr3_addr_o, rr3_data_i, fwd_valid_i, fwd_dest_i, fwd_data_i);
            d_d      = pick(rr4_addr_o, rr4_data_i, fwd_valid_i, fwd_dest_i, fwd_data_i);
            wdest_d  = !instr_i[23];
            wflags_d = instr_i[20];
        end
        if (!exec_d) begin
            wdest_d  = 1'b0;
            wflags_d = 1'b0;
        end
    end

    // Output register: load on capture, drop valid once consumed, hold otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q  <= 1'b0;
            exec_q   <= 1'b0;
            class_q  <= 2'd0;
            opcode_q <= 4'd0;
            type_q   <= 3'd0;
            dest_q   <= '0;
            a_q      <= '0;
            b_q      <= '0;
            c_q      <= '0;
            d_q      <= '0;
            wdest_q  <= 1'b0;
            wflags_q <= 1'b0;
        end else if (capture) begin
            valid_q  <= 1'b1;
            exec_q   <= exec_d;
            class_q  <= class_d;
            opcode_q <= opcode_d;
            type_q   <= type_d;
            dest_q   <= dest_d;
            a_q      <= a_d;
            b_q      <= b_d;
            c_q      <= c_d;
            d_q      <= d_d;
            wdest_q  <= wdest_d;
            wflags_q <= wflags_d;
        end else if (out_ready) begin
            valid_q  <= 1'b0;
        end
    end

    assign out_valid       = valid_q;
    assign out_exec        = exec_q;
    assign out_class       = class_q;
    assign out_opcode      = opcode_q;
    assign out_type        = type_q;
    assign out_dest        = dest_q;
    assign out_a           = a_q;
    assign out_b           = b_q;
    assign out_c           = c_q;
    assign out_d           = d_q;
    assign out_write_dest  = wdest_q;
    assign out_write_flags = wflags_q;

endmodule

// File: tb/tb_decode_stage_pipelined.sv
// Bench for decode_stage_pipelined: directed steps from the test plan followed
// by a randomized run, all checked against a behavioural decode model.
module tb_decode_stage_pipelined;

    typedef struct packed {
        logic        exec;
        logic [1:0]  cls;
        logic [3:0]  opc;
        logic [2:0]  typ;
        logic [3:0]  dest;
        logic [31:0] a, b, c, d;
        logic        wd, wf;
    } bundle_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready;
    logic [31:0] instr;
    logic [3:0]  flags;
    logic [3:0]  rr1_addr, rr2_addr, rr3_addr, rr4_addr;
    logic [31:0] rr1_data, rr2_data, rr3_data, rr4_data;
    logic [1:0]  fwd_valid;
    logic [7:0]  fwd_dest;
    logic [63:0] fwd_data;
    logic        pend_valid;
    logic [3:0]  pend_dest;
    logic        out_valid, out_ready, out_exec;
    logic [1:0]  out_class;
    logic [3:0]  out_opcode;
    logic [2:0]  out_type;
    logic [3:0]  out_dest;
    logic [31:0] out_a, out_b, out_c, out_d;
    logic        out_write_dest, out_write_flags;

    logic [31:0] regs [16];
    bundle_t     exp_q [$];
    bundle_t     obs_b;
    int          total = 0;
    int          bad   = 0;

    // clock
    always #5 clk = ~clk;

    decode_stage_pipelined dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .instr_i(instr), .flags_i(flags),
        .rr1_addr_o(rr1_addr), .rr2_addr_o(rr2_addr), .rr3_addr_o(rr3_addr), .rr4_addr_o(rr4_addr),
        .rr1_data_i(rr1_data), .rr2_data_i(rr2_data), .rr3_data_i(rr3_data), .rr4_data_i(rr4_data),
        .fwd_valid_i(fwd_valid), .fwd_dest_i(fwd_dest), .fwd_data_i(fwd_data),
        .pend_valid_i(pend_valid), .pend_dest_i(pend_dest),
        .out_valid(out_valid), .out_ready(out_ready), .out_exec(out_exec),
        .out_class(out_class), .out_opcode(out_opcode), .out_type(out_type),
        .out_dest(out_dest), .out_a(out_a), .out_b(out_b), .out_c(out_c), .out_d(out_d),
        .out_write_dest(out_write_dest), .out_write_flags(out_write_flags)
    );

    // register file behaves like same-cycle read memory
    always_comb begin
        rr1_data = regs[rr1_addr];
        rr2_data = regs[rr2_addr];
        rr3_data = regs[rr3_addr];
        rr4_data = regs[rr4_addr];
    end

    always_comb begin
        obs_b = '{exec: out_exec, cls: out_class, opc: out_opcode, typ: out_type, dest: out_dest,
                  a: out_a, b: out_b, c: out_c, d: out_d, wd: out_write_dest, wf: out_write_flags};
    end

    // ---------------- reference model ----------------
    function automatic logic [1:0] m_class(input logic [31:0] w);
        if (w[27:0] == 28'h320F000) return 2'd0;
        if (w[27:25] == 3'b000 && w[7] == 1'b1 && w[4] == 1'b1) return 2'd2;
        if (w[27:26] == 2'b00) return 2'd1;
        return 2'd3;
    endfunction

    function automatic logic m_cond(input logic [3:0] c, input logic [3:0] f);
        bit n = f[3], z = f[2], cy = f[1], v = f[0];
        bit r;
        case (c)
            0: r = z;        1: r = !z;       2: r = cy;       3: r = !cy;
            4: r = n;        5: r = !n;       6: r = v;        7: r = !v;
            8: r = cy & !z;  9: r = !cy | z;  10: r = (n == v); 11: r = (n != v);
            12: r = !z & (n == v); 13: r = z | (n != v); 14: r = 1; default: r = 0;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] m_src(input int r);
        for (int i = 0; i < 2; i++)
            if (fwd_valid[i] && int'(fwd_dest[i*4 +: 4]) == r) return fwd_data[i*32 +: 32];
        return regs[r];
    endfunction

    function automatic logic [31:0] m_ror(input logic [31:0] x, input int r);
        return (x >> r) | (x << (32 - r));
    endfunction

    function automatic bundle_t model(input logic [31:0] w, input logic [3:0] f);
        bundle_t e = '0;
        e.cls  = m_class(w);
        e.exec = m_cond(w[31:28], f);
        if (e.cls == 2'd1) begin
            e.opc  = w[24:21];
            e.dest = w[15:12];
            e.a    = m_src(int'(w[19:16]));
            e.b    = w[25] ? m_ror({24'b0, w[7:0]}, 2 * int'(w[11:8])) : m_src(int'(w[3:0]));
            if (int'(w[24:21]) >= 8 && int'(w[24:21]) <= 11) begin e.wd = 0; e.wf = 1; end
            else begin e.wd = 1; e.wf = w[20]; end
        end else if (e.cls == 2'd2) begin
            e.typ  = w[23:21];
            e.dest = w[19:16];
            e.a    = m_src(int'(w[3:0]));
            e.b    = m_src(int'(w[11:8]));
            e.c    = m_src(int'(w[19:16]));
            e.d    = m_src(int'(w[15:12]));
            e.wd   = !w[23];
            e.wf   = w[20];
        end
        if (!e.exec) begin e.wd = 0; e.wf = 0; end
        return e;
    endfunction

    function automatic logic m_hazard(input logic [31:0] w);
        int srcs [$];
        logic [1:0] k = m_class(w);
        if (k == 2'd1) begin
            srcs.push_back(int'(w[19:16]));
            if (!w[25]) srcs.push_back(int'(w[3:0]));
        end else if (k == 2'd2) begin
            srcs = '{int'(w[3:0]), int'(w[11:8]), int'(w[19:16]), int'(w[15:12])};
        end
        if (!(in_valid && pend_valid)) return 1'b0;
        foreach (srcs[i]) if (srcs[i] == int'(pend_dest)) return 1'b1;
        return 1'b0;
    endfunction

    // ---------------- checking helpers ----------------
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_bundle(input string tag, input bundle_t e);
        chk({tag, ".exec"},  out_exec, e.exec);
        chk({tag, ".class"}, out_class, e.cls);
        chk({tag, ".opc"},   out_opcode, e.opc);
        chk({tag, ".type"},  out_type, e.typ);
        chk({tag, ".dest"},  out_dest, e.dest);
        chk({tag, ".a"},     out_a, e.a);
        chk({tag, ".b"},     out_b, e.b);
        chk({tag, ".c"},     out_c, e.c);
        chk({tag, ".d"},     out_d, e.d);
        chk({tag, ".wd"},    out_write_dest, e.wd);
        chk({tag, ".wf"},    out_write_flags, e.wf);
    endtask

    // one clock: inputs already applied; predict ready, advance the model, check outputs
    task automatic tick();
        logic    pr;
        bundle_t e;
        #3;
        pr = ((exp_q.size() == 0) || out_ready) && !m_hazard(instr);
        chk("in_ready", in_ready, pr);
        e = model(instr, flags);
        @(posedge clk);
        if (rst) exp_q.delete();
        else begin
            if (out_ready && exp_q.size() != 0) void'(exp_q.pop_front());
            if (in_valid && pr) exp_q.push_back(e);
        end
        #1;
        chk("out_valid", out_valid, exp_q.size() != 0);
        if (exp_q.size() != 0) chk_bundle("bundle", exp_q[0]);
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        int k;
        w = $urandom;
        k = $urandom_range(0, 9);
        w[31:28] = (k % 2 == 0) ? 4'hE : 4'($urandom_range(0, 15));
        if (k <= 4) begin
            w[27:26] = 2'b00;
            w[19:16] = 4'($urandom_range(0, 3));
            w[3:0]   = 4'($urandom_range(0, 3));
        end else if (k <= 6) begin
            w[27:24] = 4'h0;
            w[7:4]   = 4'b1001;
            w[19:16] = 4'($urandom_range(0, 3));
            w[15:12] = 4'($urandom_range(0, 3));
            w[11:8]  = 4'($urandom_range(0, 3));
            w[3:0]   = 4'($urandom_range(0, 3));
        end else if (k == 7) begin
            w[27:0] = 28'h320F000;
        end
        return w;
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        for (int i = 0; i < 16; i++) regs[i] = $urandom;
        regs[4] = 32'h33;
        rst = 1; in_valid = 0; instr = 0; flags = 0; out_ready = 1;
        fwd_valid = 0; fwd_dest = 0; fwd_data = 0; pend_valid = 0; pend_dest = 0;
        @(posedge clk); #1;

        // reset state
        tick(); tick();
        chk("rst.out_valid", out_valid, 0);
        chk_bundle("rst", '0);
        rst = 0;

        // ADD R1,R2,#0xFF000000
        in_valid = 1; instr = 32'hE28214FF; flags = 4'b0000;
        #1 chk("add.rr1_addr", rr1_addr, 2);
        chk("add.in_ready", in_ready, 1);
        tick();
        chk("add.valid", out_valid, 1);
        chk("add.class", out_class, 1);
        chk("add.exec", out_exec, 1);
        chk("add.b", out_b, 32'hFF000000);
        chk("add.dest", out_dest, 1);
        chk("add.wd", out_write_dest, 1);
        chk("add.wf", out_write_flags, 0);

        // ADDGT, condition false then true
        instr = 32'hC28214FF; flags = 4'b1000;
        tick();
        chk("gt0.exec", out_exec, 0);
        chk("gt0.wd", out_write_dest, 0);
        chk("gt0.wf", out_write_flags, 0);
        flags = 4'b1001;
        tick();
        chk("gt1.exec", out_exec, 1);

        // SUB R3,R4,R5 with bypass priority
        instr = 32'hE0443005; flags = 4'b0000;
        fwd_valid = 2'b11; fwd_dest = {4'd4, 4'd4}; fwd_data = {32'h22, 32'h11};
        tick();
        chk("fwd0.a", out_a, 32'h11);
        fwd_valid = 2'b10;
        tick();
        chk("fwd1.a", out_a, 32'h22);
        fwd_valid = 2'b00;
        tick();
        chk("fwdn.a", out_a, 32'h33);

        // MLA R6,R7,R8,R9 with Rs pending
        instr = 32'hE0269897; pend_valid = 1; pend_dest = 4'd8;
        #1 chk("mla.in_ready", in_ready, 0);
        chk("mla.rr2_addr", rr2_addr, 8);
        tick();
        chk("mla.nocap", out_valid, 0);
        pend_valid = 0;
        tick();
        chk("mla.class", out_class, 2);
        chk("mla.type", out_type, 3'b001);
        chk("mla.wd", out_write_dest, 1);
        chk("mla.c", out_c, regs[6]);

        // backpressure for 3 cycles, then release
        out_ready = 0; instr = 32'hE28214FF;
        for (int i = 0; i < 3; i++) begin
            #1 chk("stall.in_ready", in_ready, 0);
            tick();
            chk("stall.class", out_class, 2);
        end
        out_ready = 1;
        #1 chk("rel.in_ready", in_ready, 1);
        tick();
        chk("rel.class", out_class, 1);

        // NOP then CMP R1,#0
        instr = 32'hE320F000;
        tick();
        chk("nop.class", out_class, 0);
        chk("nop.wd", out_write_dest, 0);
        chk("nop.wf", out_write_flags, 0);
        instr = 32'hE3510000;
        tick();
        chk("cmp.class", out_class, 1);
        chk("cmp.wf", out_write_flags, 1);
        chk("cmp.wd", out_write_dest, 0);

        // reset while stalled drops the bundle
        out_ready = 0; instr = 32'hE28214FF;
        tick();
        rst = 1;
        tick();
        chk("rststall.valid", out_valid, 0);
        rst = 0; out_ready = 1;

        // randomized traffic
        for (int n = 0; n < 400; n++) begin
            if (n % 50 == 0) for (int i = 0; i < 16; i++) regs[i] = $urandom;
            in_valid   = ($urandom_range(0, 9) < 8);
            out_ready  = ($urandom_range(0, 9) < 7);
            instr      = rand_instr();
            flags      = 4'($urandom_range(0, 15));
            fwd_valid  = 2'($urandom_range(0, 3));
            fwd_dest   = {4'($urandom_range(0, 3)), 4'($urandom_range(0, 3))};
            fwd_data   = {$urandom, $urandom};
            pend_valid = ($urandom_range(0, 9) < 3);
            pend_dest  = 4'($urandom_range(0, 3));
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/decode_stage_pipelined.md
Name: decode_stage_pipelined

Overview:
- Registered, parametrised ARM-subset instruction decode stage between fetch and execute.
- Classifies NOP / multiply / data-processing / undefined instructions and evaluates the condition code against live NZCV flags.
- Expands rotated immediates and forwards operands from NUM_FWD bypass ports.
- Stalls on unresolved load-use / multiply hazards; valid/ready handshake on both sides.

Parameters:
DATA_W, 32, operand/result width
REG_AW, 4, register address width (2**REG_AW registers)
NUM_FWD, 2, number of bypass ports; index 0 is the youngest stage

Ports:
clk  in  1  clock
rst  in  1  reset
in_valid  in  1  instr_i valid
in_ready  out  1  stage accepts instr_i this cycle
instr_i  in  32  instruction word
flags_i  in  4  NZCV, bit3=N, bit2=Z, bit1=C, bit0=V
rr1_addr_o, rr2_addr_o, rr3_addr_o, rr4_addr_o  out  REG_AW each  register-file read addresses
rr1_data_i, rr2_data_i, rr3_data_i, rr4_data_i  in  DATA_W each  register-file read data, same cycle
fwd_valid_i  in  NUM_FWD  bypass entry valid
fwd_dest_i  in  NUM_FWD*REG_AW  bypass destinations, packed
fwd_data_i  in  NUM_FWD*DATA_W  bypass data, packed
pend_valid_i  in  1  in-flight result not yet available
pend_dest_i  in  REG_AW  destination of that result
out_valid  out  1  decoded bundle valid
out_ready  in  1  execute accepts bundle
out_exec  out  1  condition passed
out_class  out  2  0=NOP, 1=DP, 2=MUL, 3=UNDEF
out_opcode  out  4  DP opcode
out_type  out  3  multiply type, instr[23:21]
out_dest  out  REG_AW  destination register
out_a, out_b, out_c, out_d  out  DATA_W each  operands
out_write_dest  out  1  write destination register
out_write_flags  out  1  update NZCV

Behaviour:

Reset
- rst is synchronous, active-high.
- On reset, every out_* register is 0 and out_valid=0.
- Reset mid-stall drops the held bundle.

Classification (from instr_i)
- NOP: instr[27:0]=0x320F000 -> class 0.
- MUL: instr[27:25]=000, bit7=1, bit4=1 -> class 2.
- DP: instr[27:26]=00, not MUL -> class 1.
- UNDEF: anything else -> class 3.

Read addresses (combinational from instr_i)
- DP: rr1=Rn[19:16], rr2=Rm[3:0].
- MUL: rr1=Rm[3:0], rr2=Rs[11:8], rr3=Rd[19:16], rr4=Rn[15:12].
- NOP / UNDEF: all 0.

Operand selection
- Per source, the lowest-index fwd port with fwd_valid_i set and matching dest supplies the data; otherwise rrN_data_i.
- DP with I=1 (bit25): out_b = zero-extended imm8 rotated right by 2*instr[11:8].
- DP with I=0: out_b = forwarded or read Rm. Shifts are not decoded; shift bits are ignored.
- Unused operands are 0.

Destination and write enables
- DP: out_dest=instr[15:12], out_opcode=instr[24:21].
- DP opcodes 1000-1011 (TST/TEQ/CMP/CMN): out_write_dest=0, out_write_flags=1.
- Other DP opcodes: out_write_dest=1, out_write_flags=instr[20].
- MUL: out_dest=instr[19:16], out_write_dest=!instr[23], out_write_flags=instr[20], out_type=instr[23:21].

Condition evaluation (uses flags_i at the capture cycle)
- EQ Z; NE !Z; CS C; CC !C; MI N; PL !N; VS V; VC !V.
- HI C&!Z; LS !C|Z; GE N==V; LT N!=V; GT !Z&(N==V); LE Z|(N!=V).
- AL 1; 1111 0.
- When out_exec=0 or class is NOP/UNDEF: out_write_dest=0 and out_write_flags=0.

Hazard
- hazard = in_valid & pend_valid_i & (pend_dest_i equals any used source address of the current class).
- Unused read ports never hazard.

Handshake
- in_ready = (!out_valid | out_ready) & !hazard.
- Capture occurs when in_valid & in_ready; latency is 1 cycle.
- If out_valid & !out_ready, all outputs hold stable.
- If out_ready with no capture, out_valid drops to 0 next cycle.
- Simultaneous accept-out and capture-in gives back-to-back throughput of 1 per cycle.

Test Plan:
- ADD R1,R2,#0xFF000000 (0xE28214FF), flags 0000 -> out_class=1, out_exec=1, out_b=0xFF000000, out_dest=1, out_write_dest=1, out_write_flags=0; out_valid next cycle.
- ADDGT with flags Z=0,N=1,V=0 -> out_exec=0 and both write enables 0. Same instruction with N=V=1 -> out_exec=1.
- SUB R3,R4,R5 with fwd0{dest 4, 0x11} and fwd1{dest 4, 0x22} both valid, rr1_data_i=0x33 -> out_a=0x11. fwd0 invalid -> out_a=0x22.
- MLA R6,R7,R8,R9 (0xE0269897), pend_dest_i=8, pend_valid_i=1 -> in_ready=0 and no capture. pend_valid_i=0 -> capture with out_class=2, out_type=001, out_write_dest=1.
- out_ready=0 for 3 cycles with in_valid held -> outputs stable and in_ready=0. out_ready=1 -> new bundle captured the same cycle.
- NOP 0xE320F000 then CMP R1,#0 -> class 0 with no writes, then class 1 with out_write_flags=1 and out_write_dest=0. rst asserted during a stall -> out_valid=0 next cycle.
